// File: rtl/pcie_gen1_lpif_phy.sv
`default_nettype none
// ============================================================================
// Module   : pcie_gen1_lpif_phy
// Brief    : Gen1 PHY shim between a 64-byte LPIF link layer and a 16-lane
//            8-bit PIPE: detect, reduced polling, L0 byte striping.
// Revision : 1.0
// ============================================================================
module pcie_gen1_lpif_phy #(
    parameter int MAXPIPEWIDTH   = 32,
    parameter int DEVICETYPE     = 0,
    parameter int LANESNUMBER    = 16,
    parameter int GEN1_PIPEWIDTH = 8,
    parameter int GEN2_PIPEWIDTH = 8,
    parameter int GEN3_PIPEWIDTH = 8,
    parameter int GEN4_PIPEWIDTH = 8,
    parameter int GEN5_PIPEWIDTH = 8,
    parameter int MAX_GEN        = 1
) (
    input  logic                                CLK,
    input  logic                                reset,
    output logic                                phy_reset,
    output logic [1:0]                          width,
    output logic [MAXPIPEWIDTH*LANESNUMBER-1:0] TxData,
    output logic [LANESNUMBER-1:0]              TxDataValid,
    output logic [LANESNUMBER-1:0]              TxElecIdle,
    output logic [LANESNUMBER-1:0]              TxDetectRx_Loopback,
    output logic [4*LANESNUMBER-1:0]            TxDataK,
    output logic [LANESNUMBER-1:0]              TxStartBlock,
    output logic [2*LANESNUMBER-1:0]            TxSyncHeader,
    input  logic [MAXPIPEWIDTH*LANESNUMBER-1:0] RxData,
    input  logic [4*LANESNUMBER-1:0]            RxDataK,
    input  logic [LANESNUMBER-1:0]              RxDataValid,
    input  logic [3*LANESNUMBER-1:0]            RxStatus,
    input  logic [LANESNUMBER-1:0]              PhyStatus,
    input  logic [LANESNUMBER-1:0]              RxStartBlock,
    input  logic [2*LANESNUMBER-1:0]            RxSyncHeader,
    input  logic [LANESNUMBER-1:0]              RxElectricalIdle,
    output logic [4*LANESNUMBER-1:0]            PowerDown,
    output logic [3:0]                          Rate,
    output logic [4:0]                          PCLKRate,
    output logic [17:0]                         TxDeemph,
    output logic [4:0]                          LocalPresetIndex,
    output logic                                GetLocalPresetCoeffcients,
    input  logic [17:0]                         LocalTxPresetCoefficients,
    input  logic [5:0]                          LocalFS,
    input  logic [5:0]                          LocalLF,
    input  logic                                LocalTxCoefficientsValid,
    output logic [5:0]                          LF,
    output logic [5:0]                          FS,
    output logic                                RxEqEval,
    output logic                                InvalidRequest,
    input  logic [5:0]                          LinkEvaluationFeedbackDirectionChange,
    output logic                                PclkChangeAck,
    input  logic                                PclkChangeOk,
    output logic [7:0]                          M2P_MessageBus,
    input  logic [7:0]                          P2M_MessageBus,
    input  logic                                lp_irdy,
    output logic                                pl_trdy,
    input  logic [511:0]                        lp_data,
    input  logic [63:0]                         lp_valid,
    output logic [511:0]                        pl_data,
    output logic [63:0]                         pl_valid,
    input  logic [3:0]                          lp_state_req,
    output logic [3:0]                          pl_state_sts,
    input  logic                                lp_force_detect,
    output logic                                linkUp,
    output logic [2:0]                          pl_speedmode,
    input  logic [63:0]                         lp_tlpstart,
    input  logic [63:0]                         lp_tlpend,
    input  logic [63:0]                         lp_dlpstart,
    input  logic [63:0]                         lp_dlpend,
    output logic [63:0]                         pl_tlpstart,
    output logic [63:0]                         pl_tlpend,
    output logic [63:0]                         pl_dlpstart,
    output logic [63:0]                         pl_dlpend,
    output logic [63:0]                         pl_tlpedb
);

    localparam int         c_LANES = 16;
    localparam logic [7:0] c_COM   = 8'hBC;
    localparam logic [7:0] c_PAD   = 8'hF7;

    typedef enum logic [1:0] {
        DETECT_QUIET  = 2'd0,
        DETECT_ACTIVE = 2'd1,
        POLLING       = 2'd2,
        L0            = 2'd3
    } state_t;

    state_t         r_state, w_next;
    logic [3:0]     r_quietCnt, r_comCnt;
    logic           r_retrain, w_retrainEntry, w_retrainNext;
    logic           r_txBusy;
    logic [1:0]     r_txBeat, r_rxBeat;
    logic [511:0]   r_txBuf;
    logic [63:0]    r_txBufValid;
    logic [383:0]   r_rxBuf;
    logic [47:0]    r_rxBufValid;
    logic [127:0]   r_txByte, w_beatByte, w_rxByte;
    logic [15:0]    r_txK, w_beatK, w_rxVal;
    logic           r_txValid, r_elecIdle, r_p1, r_detect, r_trdy, r_linkUp;
    logic [3:0]     r_sts;
    logic [511:0]   r_plData;
    logic [63:0]    r_plValid;
    logic           w_handshake, w_comMatch;

    always_comb begin
        w_next = r_state;
        case (r_state)
            DETECT_QUIET:  if (r_quietCnt == 4'd15) w_next = DETECT_ACTIVE;
            DETECT_ACTIVE: if (PhyStatus[0])
                               w_next = (RxStatus[2:0] == 3'b011) ? POLLING : DETECT_QUIET;
            POLLING:       if (r_comCnt == 4'd8) w_next = L0;
            L0:            if (lp_state_req == 4'd2) w_next = POLLING;
            default:       w_next = DETECT_QUIET;
        endcase
        if (lp_force_detect)
            w_next = DETECT_QUIET;
    end

    assign w_retrainEntry = (r_state == L0) && (w_next == POLLING);
    assign w_retrainNext  = w_retrainEntry || (r_state == POLLING && w_next == POLLING && r_retrain);
    assign w_handshake    = lp_irdy && r_trdy && (w_next == L0);
    assign w_comMatch     = RxDataValid[0] && RxDataK[0] && (RxData[7:0] == c_COM);

    // Lane l of beat b carries chunk byte 16b+l; invalid bytes go out as PAD/K.
    always_comb begin
        w_beatByte = '0;
        w_beatK    = '0;
        w_rxByte   = '0;
        w_rxVal    = '0;
        for (int l = 0; l < c_LANES; l++) begin
            if (r_txBufValid[16*int'(r_txBeat) + l]) begin
                w_beatByte[8*l +: 8] = r_txBuf[128*int'(r_txBeat) + 8*l +: 8];
            end else begin
                w_beatByte[8*l +: 8] = c_PAD;
                w_beatK[l]           = 1'b1;
            end
            w_rxVal[l]         = !RxDataK[4*l];
            w_rxByte[8*l +: 8] = RxDataK[4*l] ? 8'h00 : RxData[MAXPIPEWIDTH*l +: 8];
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state      <= DETECT_QUIET;
            r_quietCnt   <= '0;
            r_comCnt     <= '0;
            r_retrain    <= 1'b0;
            r_txBusy     <= 1'b0;
            r_txBeat     <= '0;
            r_rxBeat     <= '0;
            r_txBuf      <= '0;
            r_txBufValid <= '0;
            r_rxBuf      <= '0;
            r_rxBufValid <= '0;
            r_txByte     <= '0;
            r_txK        <= '0;
            r_txValid    <= 1'b0;
            r_elecIdle   <= 1'b1;
            r_p1         <= 1'b1;
            r_detect     <= 1'b0;
            r_trdy       <= 1'b0;
            r_linkUp     <= 1'b0;
            r_sts        <= '0;
            r_plData     <= '0;
            r_plValid    <= '0;
        end else begin
            r_state    <= w_next;
            r_quietCnt <= (r_state == DETECT_QUIET && w_next == DETECT_QUIET) ? r_quietCnt + 4'd1 : 4'd0;
            if (r_state == POLLING && w_next == POLLING)
                r_comCnt <= w_comMatch ? r_comCnt + 4'd1 : 4'd0;
            else
                r_comCnt <= 4'd0;
            r_retrain <= w_retrainNext;

            if (w_next != L0) begin
                r_txBusy <= 1'b0;
                r_txBeat <= 2'd0;
            end else if (w_handshake) begin
                r_txBuf      <= lp_data;
                r_txBufValid <= lp_valid;
                r_txBusy     <= 1'b1;
                r_txBeat     <= 2'd0;
            end else if (r_txBusy) begin
                r_txBeat <= r_txBeat + 2'd1;
                if (r_txBeat == 2'd3)
                    r_txBusy <= 1'b0;
            end

            r_plData  <= '0;
            r_plValid <= '0;
            if (r_state != L0 || w_next != L0) begin
                r_rxBeat <= 2'd0;
            end else if (RxDataValid[0]) begin
                r_rxBeat <= r_rxBeat + 2'd1;
                case (r_rxBeat)
                    2'd0: begin r_rxBuf[127:0]   <= w_rxByte; r_rxBufValid[15:0]  <= w_rxVal; end
                    2'd1: begin r_rxBuf[255:128] <= w_rxByte; r_rxBufValid[31:16] <= w_rxVal; end
                    2'd2: begin r_rxBuf[383:256] <= w_rxByte; r_rxBufValid[47:32] <= w_rxVal; end
                    default: begin
                        r_plData  <= {w_rxByte, r_rxBuf};
                        r_plValid <= {w_rxVal, r_rxBufValid};
                    end
                endcase
            end

            // Outputs follow the state being entered so they line up with r_state.
            r_elecIdle <= (w_next == DETECT_QUIET) || (w_next == DETECT_ACTIVE);
            r_p1       <= (w_next == DETECT_QUIET) || (w_next == DETECT_ACTIVE);
            r_detect   <= (w_next == DETECT_ACTIVE);
            r_linkUp   <= (w_next == L0);
            r_trdy     <= (w_next == L0) && !r_txBusy && !w_handshake;
            if (w_next == L0 && lp_state_req == 4'd1)
                r_sts <= 4'd1;
            else if (w_next == POLLING && w_retrainNext)
                r_sts <= 4'd2;
            else
                r_sts <= 4'd0;

            if (w_next == POLLING) begin
                r_txValid <= 1'b1;
                r_txByte  <= {c_LANES{c_COM}};
                r_txK     <= '1;
            end else if (w_next == L0 && r_txBusy) begin
                r_txValid <= 1'b1;
                r_txByte  <= w_beatByte;
                r_txK     <= w_beatK;
            end else begin
                r_txValid <= 1'b0;
                r_txByte  <= '0;
                r_txK     <= '0;
            end
        end
    end

    generate
        for (genvar l = 0; l < LANESNUMBER; l++) begin : g_lane
            assign TxData[MAXPIPEWIDTH*l +: MAXPIPEWIDTH] =
                {{(MAXPIPEWIDTH-8){1'b0}}, r_txByte[8*(l % c_LANES) +: 8]};
            assign TxDataK[4*l +: 4]   = {3'b000, r_txK[l % c_LANES]};
            assign PowerDown[4*l +: 4] = r_p1 ? 4'b0010 : 4'b0000;
        end
    endgenerate

    assign phy_reset           = reset;
    assign width               = 2'b00;
    assign TxDataValid         = {LANESNUMBER{r_txValid}};
    assign TxElecIdle          = {LANESNUMBER{r_elecIdle}};
    assign TxDetectRx_Loopback = {LANESNUMBER{r_detect}};
    assign pl_trdy             = r_trdy;
    assign linkUp              = r_linkUp;
    assign pl_state_sts        = r_sts;
    assign pl_data             = r_plData;
    assign pl_valid            = r_plValid;

    assign TxStartBlock              = '0;
    assign TxSyncHeader              = '0;
    assign Rate                      = '0;
    assign PCLKRate                  = '0;
    assign TxDeemph                  = '0;
    assign LocalPresetIndex          = '0;
    assign GetLocalPresetCoeffcients = 1'b0;
    assign LF                        = '0;
    assign FS                        = '0;
    assign RxEqEval                  = 1'b0;
    assign InvalidRequest            = 1'b0;
    assign PclkChangeAck             = 1'b0;
    assign M2P_MessageBus            = '0;
    assign pl_speedmode              = '0;
    assign pl_tlpstart               = '0;
    assign pl_tlpend                 = '0;
    assign pl_dlpstart               = '0;
    assign pl_dlpend                 = '0;
    assign pl_tlpedb                 = '0;

    logic w_unused;
    assign w_unused = ^{DEVICETYPE, GEN1_PIPEWIDTH, GEN2_PIPEWIDTH, GEN3_PIPEWIDTH,
                        GEN4_PIPEWIDTH, GEN5_PIPEWIDTH, MAX_GEN, RxData, RxDataK,
                        RxDataValid, RxStatus, PhyStatus, RxStartBlock, RxSyncHeader,
                        RxElectricalIdle, LocalTxPresetCoefficients, LocalFS, LocalLF,
                        LocalTxCoefficientsValid, LinkEvaluationFeedbackDirectionChange,
                        PclkChangeOk, P2M_MessageBus, lp_tlpstart, lp_tlpend,
                        lp_dlpstart, lp_dlpend};

endmodule
`default_nettype wire

// File: tb/tb_pcie_gen1_lpif_phy.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_gen1_lpif_phy
// Brief    : Directed bench: detect/retry, polling, L0 loopback chunks, retrain.
// Revision : 1.0
// ============================================================================
module tb_pcie_gen1_lpif_phy;

    logic         CLK = 1'b0;
    logic         reset;
    logic         phy_reset;
    logic [1:0]   width;
    logic [511:0] TxData;
    logic [15:0]  TxDataValid, TxElecIdle, TxDetectRx_Loopback, TxStartBlock;
    logic [63:0]  TxDataK;
    logic [31:0]  TxSyncHeader;
    logic [511:0] RxData;
    logic [63:0]  RxDataK;
    logic [15:0]  RxDataValid, PhyStatus;
    logic [47:0]  RxStatus;
    logic [63:0]  PowerDown;
    logic [3:0]   Rate;
    logic [4:0]   PCLKRate;
    logic [17:0]  TxDeemph;
    logic [4:0]   LocalPresetIndex;
    logic         GetLocalPresetCoeffcients, RxEqEval, InvalidRequest, PclkChangeAck;
    logic [5:0]   LF, FS;
    logic [7:0]   M2P_MessageBus;
    logic         lp_irdy, pl_trdy, lp_force_detect, linkUp;
    logic [511:0] lp_data, pl_data;
    logic [63:0]  lp_valid, pl_valid;
    logic [3:0]   lp_state_req, pl_state_sts;
    logic [2:0]   pl_speedmode;
    logic [63:0]  pl_tlpstart, pl_tlpend, pl_dlpstart, pl_dlpend, pl_tlpedb;
    logic         loopEn;

    int checks   = 0;
    int failures = 0;

    // Zero-latency PIPE loopback
    assign RxData      = loopEn ? TxData      : '0;
    assign RxDataK     = loopEn ? TxDataK     : '0;
    assign RxDataValid = loopEn ? TxDataValid : '0;

    always #5 CLK = ~CLK;

    pcie_gen1_lpif_phy dut (
        .CLK(CLK), .reset(reset), .phy_reset(phy_reset), .width(width),
        .TxData(TxData), .TxDataValid(TxDataValid), .TxElecIdle(TxElecIdle),
        .TxDetectRx_Loopback(TxDetectRx_Loopback), .TxDataK(TxDataK),
        .TxStartBlock(TxStartBlock), .TxSyncHeader(TxSyncHeader),
        .RxData(RxData), .RxDataK(RxDataK), .RxDataValid(RxDataValid),
        .RxStatus(RxStatus), .PhyStatus(PhyStatus), .RxStartBlock(16'h0),
        .RxSyncHeader(32'h0), .RxElectricalIdle(16'h0), .PowerDown(PowerDown),
        .Rate(Rate), .PCLKRate(PCLKRate), .TxDeemph(TxDeemph),
        .LocalPresetIndex(LocalPresetIndex), .GetLocalPresetCoeffcients(GetLocalPresetCoeffcients),
        .LocalTxPresetCoefficients(18'h0), .LocalFS(6'h0), .LocalLF(6'h0),
        .LocalTxCoefficientsValid(1'b0), .LF(LF), .FS(FS), .RxEqEval(RxEqEval),
        .InvalidRequest(InvalidRequest), .LinkEvaluationFeedbackDirectionChange(6'h0),
        .PclkChangeAck(PclkChangeAck), .PclkChangeOk(1'b0),
        .M2P_MessageBus(M2P_MessageBus), .P2M_MessageBus(8'h0),
        .lp_irdy(lp_irdy), .pl_trdy(pl_trdy), .lp_data(lp_data), .lp_valid(lp_valid),
        .pl_data(pl_data), .pl_valid(pl_valid), .lp_state_req(lp_state_req),
        .pl_state_sts(pl_state_sts), .lp_force_detect(lp_force_detect), .linkUp(linkUp),
        .pl_speedmode(pl_speedmode), .lp_tlpstart(64'h0), .lp_tlpend(64'h0),
        .lp_dlpstart(64'h0), .lp_dlpend(64'h0), .pl_tlpstart(pl_tlpstart),
        .pl_tlpend(pl_tlpend), .pl_dlpstart(pl_dlpstart), .pl_dlpend(pl_dlpend),
        .pl_tlpedb(pl_tlpedb)
    );

    task automatic checkVal(input string tag, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One LPIF chunk through the loopback; expectations built from d/v only.
    task automatic sendChunk(input logic [511:0] d, input logic [63:0] v);
        logic [511:0] expTx, expRx;
        logic [63:0]  expK;
        int           k;
        lp_data  = d;
        lp_valid = v;
        lp_irdy  = 1'b1;
        tick();
        lp_irdy = 1'b0;
        checkVal("trdy_after_hs", pl_trdy, 1'b0);
        for (int b = 0; b < 4; b++) begin
            tick();
            expTx = '0;
            expK  = '0;
            for (int l = 0; l < 16; l++) begin
                k = 16*b + l;
                if (v[k]) begin
                    expTx[32*l +: 8] = d[8*k +: 8];
                end else begin
                    expTx[32*l +: 8] = 8'hF7;
                    expK[4*l]        = 1'b1;
                end
            end
            checkVal($sformatf("tx_beat%0d_data", b), TxData, expTx);
            checkVal($sformatf("tx_beat%0d_k", b), TxDataK, expK);
            checkVal($sformatf("tx_beat%0d_valid", b), TxDataValid, 16'hFFFF);
            checkVal($sformatf("tx_beat%0d_trdy", b), pl_trdy, 1'b0);
        end
        tick();
        expRx = '0;
        for (int j = 0; j < 64; j++)
            if (v[j]) expRx[8*j +: 8] = d[8*j +: 8];
        checkVal("rx_data", pl_data, expRx);
        checkVal("rx_valid", pl_valid, v);
        checkVal("trdy_return", pl_trdy, 1'b1);
        checkVal("tx_idle", TxDataValid, 16'h0);
        checkVal("sts_active", pl_state_sts, 4'd1);
        tick();
        checkVal("rx_valid_pulse", pl_valid, 64'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int           n;
        logic [511:0] d;
        reset           = 1'b1;
        loopEn          = 1'b0;
        PhyStatus       = '0;
        RxStatus        = '0;
        lp_irdy         = 1'b0;
        lp_data         = '0;
        lp_valid        = '0;
        lp_state_req    = 4'd1;
        lp_force_detect = 1'b0;

        repeat (3) tick();
        checkVal("rst_elecidle", TxElecIdle, 16'hFFFF);
        checkVal("rst_powerdown", PowerDown, {16{4'b0010}});
        checkVal("rst_linkup", linkUp, 1'b0);
        checkVal("rst_trdy", pl_trdy, 1'b0);
        checkVal("rst_phy_reset", phy_reset, 1'b1);

        reset = 1'b0;
        n = 0;
        do begin tick(); n++; end while (TxDetectRx_Loopback != 16'hFFFF && n < 64);
        checkVal("quiet_cycles", n, 16);

        // Detect retry: no receiver reported
        PhyStatus = 16'h0001;
        RxStatus  = '0;
        tick();
        PhyStatus = '0;
        checkVal("retry_detect_off", TxDetectRx_Loopback, 16'h0);
        checkVal("retry_elecidle", TxElecIdle, 16'hFFFF);
        n = 0;
        do begin tick(); n++; end while (TxDetectRx_Loopback != 16'hFFFF && n < 64);
        checkVal("requiet_cycles", n, 16);

        PhyStatus = 16'hFFFF;
        RxStatus  = {16{3'b011}};
        loopEn    = 1'b1;
        tick();
        PhyStatus = '0;
        checkVal("poll_txdata", TxData, {16{32'h000000BC}});
        checkVal("poll_txk", TxDataK, {16{4'b0001}});
        checkVal("poll_valid", TxDataValid, 16'hFFFF);
        checkVal("poll_elecidle", TxElecIdle, 16'h0);
        checkVal("poll_detect", TxDetectRx_Loopback, 16'h0);
        checkVal("poll_powerdown", PowerDown, 64'h0);
        checkVal("poll_sts", pl_state_sts, 4'd0);
        n = 0;
        do begin tick(); n++; end while (linkUp !== 1'b1 && n < 64);
        checkVal("linkup_cycles", n, 9);
        checkVal("l0_trdy", pl_trdy, 1'b1);
        checkVal("l0_sts", pl_state_sts, 4'd1);
        checkVal("l0_idle_data", TxData, 512'h0);

        tick();
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        sendChunk(d, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        sendChunk(d, 64'h0000_0000_FFFF_FFFF);
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        sendChunk(d, 64'hA5A5_0F0F_FF00_1234);

        // Retrain back through polling
        lp_state_req = 4'd2;
        tick();
        lp_state_req = 4'd1;
        checkVal("retrain_linkup", linkUp, 1'b0);
        checkVal("retrain_sts", pl_state_sts, 4'd2);
        checkVal("retrain_txdata", TxData, {16{32'h000000BC}});
        n = 0;
        do begin tick(); n++; end while (linkUp !== 1'b1 && n < 64);
        checkVal("relink_cycles", n, 9);
        checkVal("relink_sts", pl_state_sts, 4'd1);

        // Force-detect wins over a simultaneous retrain
        lp_state_req    = 4'd2;
        lp_force_detect = 1'b1;
        tick();
        lp_state_req    = 4'd1;
        lp_force_detect = 1'b0;
        checkVal("force_elecidle", TxElecIdle, 16'hFFFF);
        checkVal("force_linkup", linkUp, 1'b0);
        checkVal("force_sts", pl_state_sts, 4'd0);
        checkVal("force_powerdown", PowerDown, {16{4'b0010}});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pcie_gen1_lpif_phy.md
# pcie_gen1_lpif_phy

Simplified Gen1 physical layer between the link layer's LPIF-style byte interface and a 16-lane, 8-bit-per-lane PIPE interface. It runs receiver detection, a reduced Polling handshake, and asserts `linkUp` in L0. In L0 it stripes 64-byte link-layer chunks across the lanes and reassembles received beats into 64-byte chunks. Equalization, rate change, message bus and framing transport are tied off in this revision.

## Interface
- `MAXPIPEWIDTH`, 32: per-lane PIPE slot width; only bits [7:0] of each slot are used.
- `DEVICETYPE`, 0: 0 = downstream, 1 = upstream; no behavioural effect in this revision.
- `LANESNUMBER`, 16: lane count; the datapath is fixed at 16.
- `GEN1_PIPEWIDTH`..`GEN5_PIPEWIDTH`, 8: per-generation PIPE width; only Gen1 is used.
- `MAX_GEN`, 1: highest supported generation.
- `CLK`  in  1  PCLK; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `phy_reset`  out  1  equals `reset`, combinational.
- `width`  out  2  constant 2'b00 (8-bit PIPE).
- `TxData`  out  32*16  lane i byte at [32i+:8]; upper 24 bits are 0.
- `TxDataValid`, `TxElecIdle`, `TxDetectRx_Loopback`  out  16 each  per-lane PIPE controls.
- `TxDataK`  out  4*16  K flag for lane i at bit [4i]; other bits are 0.
- `RxData`  in  32*16, `RxDataK`  in  4*16, `RxDataValid`  in  16  received data, same layout as Tx.
- `RxStatus`  in  3*16  lane i at [3i+:3]; 3'b011 means receiver detected.
- `PhyStatus`  in  16  PHY completion strobe.
- `PowerDown`  out  4*16  per lane: P0 = 4'b0000, P1 = 4'b0010.
- `Rate`  out  4, `PCLKRate`  out  5, `pl_speedmode`  out  3  all constant 0 (Gen1).
- `lp_irdy`  in  1, `pl_trdy`  out  1  transmit handshake.
- `lp_data`  in  512, `lp_valid`  in  64  64-byte chunk, byte k at [8k+:8], with per-byte valid.
- `pl_data`  out  512, `pl_valid`  out  64  received chunk and per-byte valid.
- `lp_state_req`  in  4  0 = reset, 1 = active, 2 = retrain.
- `pl_state_sts`  out  4  status, same encoding as `lp_state_req`.
- `lp_force_detect`  in  1  forces the Detect state.
- `linkUp`  out  1  high in L0.
- `pl_tlpstart`, `pl_tlpend`, `pl_dlpstart`, `pl_dlpend`, `pl_tlpedb`  out  64 each  constant 0.
- Tied-off outputs, all 0: `TxStartBlock`, `TxSyncHeader`, `TxDeemph`, `LocalPresetIndex`, `GetLocalPresetCoeffcients`, `LF`, `FS`, `RxEqEval`, `InvalidRequest`, `PclkChangeAck`, `M2P_MessageBus`.
- Ignored inputs: `RxStartBlock`, `RxSyncHeader`, `RxElectricalIdle`, `PclkChangeOk`, `LocalTxPresetCoefficients`, `LocalFS`, `LocalLF`, `LocalTxCoefficientsValid`, `LinkEvaluationFeedbackDirectionChange`, `P2M_MessageBus`, `lp_tlpstart`, `lp_tlpend`, `lp_dlpstart`, `lp_dlpend`.

## Operation
- **States:** DETECT_QUIET, DETECT_ACTIVE, POLLING, L0.
- **Reset:** the state machine enters DETECT_QUIET.
- **DETECT_QUIET:** `TxElecIdle` = all 1, `PowerDown` = P1 on all lanes. After 16 cycles, go to DETECT_ACTIVE.
- **DETECT_ACTIVE:** `TxDetectRx_Loopback` = all 1.
  - On the first cycle with `PhyStatus[0]` = 1: if `RxStatus[2:0]` = 3'b011, go to POLLING; otherwise go to DETECT_QUIET.
- **POLLING:** `TxDetectRx_Loopback` = 0, `TxElecIdle` = 0, `PowerDown` = P0.
  - Every cycle, all lanes send 0xBC (K28.5) with K = 1 and `TxDataValid` = all 1.
  - A counter tracks consecutive cycles with `RxDataValid[0]` = 1, `RxDataK[0]` = 1 and `RxData[7:0]` = 0xBC; any other cycle clears it.
  - When the count reaches 8, go to L0.
- **L0:** `linkUp` = 1.
  - Idle cycles: `TxDataValid` = 0, `TxData` = 0.
  - `pl_trdy` = 1 when no chunk is in flight.
  - On `lp_irdy` & `pl_trdy`, capture `lp_data`/`lp_valid`; then send beats b = 0..3 on the next 4 cycles, with `pl_trdy` = 0 during those cycles.
  - In beat b, lane l carries byte k = 16b + l. A valid byte goes as data with K = 0; an invalid byte goes as PAD 0xF7 with K = 1. `TxDataValid` = all 1.
- **L0 receive:**
  - Each cycle with `RxDataValid[0]` = 1 is one beat; a 2-bit counter selects b.
  - Byte k is stored as `RxData` lane l, with byte valid = !`RxDataK`[4l].
  - A K byte is stored as 0x00 with valid 0.
  - After beat 3, `pl_data`/`pl_valid` update for exactly one cycle; they are 0 otherwise.
- **Leaving L0:**
  - `lp_state_req` = 2 → POLLING; both beat counters clear and `linkUp` drops.
  - `lp_force_detect` in any state → DETECT_QUIET.
- **`pl_state_sts`:** 1 when in L0 and `lp_state_req` = 1; 2 in POLLING entered via retrain; 0 otherwise.

## Timing
- All outputs are registered except `phy_reset`.
- **Reset values:** all outputs 0, except `TxElecIdle` = all 1 and `PowerDown` = P1 on every lane. Reset asserted mid-chunk discards the chunk.
- With a zero-latency loopback, `linkUp` rises 9 cycles after POLLING is entered.
- **Transmit latency:** handshake at edge N; beat 0 appears after edge N+1; beat 3 after edge N+4; `pl_trdy` returns high after edge N+5.
- **Receive latency:** `pl_valid`/`pl_data` are valid the cycle after beat 3 is received.
- **Simultaneous events:** `lp_force_detect` has priority over retrain. A handshake in the cycle that retrain is requested is dropped.

## Test plan
- **Reset hold:** hold `reset` = 1 → `TxElecIdle` = 16'hFFFF, every `PowerDown` lane = 4'b0010, `linkUp` = 0.
- **Detect to L0:** release reset; on `TxDetectRx_Loopback` high drive `PhyStatus` = 16'hFFFF, `RxStatus` = 16 × 3'b011; loop Tx back to Rx.
  - Expect POLLING with 0xBC/K on all lanes, then `linkUp` = 1 after 9 cycles.
- **Detect retry:** `RxStatus` = 0 with `PhyStatus` = 1 → return to DETECT_QUIET, then re-detect after 16 cycles.
- **Full loopback chunk:** in L0 with `lp_state_req` = 1, pulse `lp_irdy` one cycle with random `lp_data` and `lp_valid` = all 1.
  - Expect `pl_trdy` low for 4 cycles, `TxData` lane 0 of beat 0 = `lp_data[7:0]`, then `pl_data` == `lp_data` and `pl_valid` = all 1 for one cycle; `pl_state_sts` = 1.
- **Partial valid:** `lp_valid` = 64'h00000000FFFFFFFF → bytes 32..63 sent as 0xF7/K; received `pl_valid` = 64'h00000000FFFFFFFF and upper `pl_data` = 0.
- **Retrain:** `lp_state_req` = 2 in L0 → `linkUp` = 0, `pl_state_sts` = 2, then L0 is re-entered after 8 COM beats.
